nios_pio_ext: RTL and testbench

NIOS_PIO_EXT -- requirements
Module: nios_pio_ext

---
 rtl/nios_pio_pkg.sv | 20 ++
 rtl/nios_pio_edge_sync.sv | 41 ++++
 rtl/nios_pio_ext.sv | 112 +++++++++++
 tb/tb_nios_pio_ext.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_pio_pkg.sv
// Shared constants for the extended PIO: register word offsets and edge-select encodings.
package nios_pio_pkg;

    typedef enum logic [2:0] {
        REG_DATA   = 3'd0,
        REG_DIR    = 3'd1,
        REG_MASK   = 3'd2,
        REG_EDGE   = 3'd3,
        REG_OUTSET = 3'd4,
        REG_OUTCLR = 3'd5
    } reg_off_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Final value of the post-reset arming counter; capture is enabled once it is reached.
    localparam logic [1:0] ARM_DONE = 2'd3;

endpackage

// File: rtl/nios_pio_edge_sync.sv
// One input bit: two-flop synchroniser, previous-sample register and edge detector.
module nios_pio_edge_sync
    import nios_pio_pkg::*;
#(
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    output logic sync_o,
    output logic edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_comb begin
        edge_o = 1'b0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_o = sync2_q & ~prev_q;
            EDGE_FALL: edge_o = ~sync2_q & prev_q;
            default:   edge_o = sync2_q ^ prev_q;
        endcase
    end

    assign sync_o = sync2_q;

endmodule

// File: rtl/nios_pio_ext.sv
// Avalon-style PIO with direction, interrupt mask, edge capture and atomic set/clear of outputs.
module nios_pio_ext
    import nios_pio_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 11,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    EDGE_TYPE   = EDGE_RISE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] oe,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [DATA_WIDTH-1:0] dir_q,      dir_d;
    logic [DATA_WIDTH-1:0] mask_q,     mask_d;
    logic [DATA_WIDTH-1:0] edge_q,     edge_d;
    logic [31:0]           readdata_q, readdata_d;
    logic [1:0]            arm_cnt_q,  arm_cnt_d;

    logic [DATA_WIDTH-1:0] sync_w;
    logic [DATA_WIDTH-1:0] det_w;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wr_en;
    logic                  armed;
    logic                  unused_wr_bits;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        nios_pio_edge_sync #(
            .EDGE_TYPE(EDGE_TYPE)
        ) u_edge_sync (
            .clk    (clk),
            .reset_n(reset_n),
            .in_i   (in_port[i]),
            .sync_o (sync_w[i]),
            .edge_o (det_w[i])
        );
    end

    assign wdata          = writedata[DATA_WIDTH-1:0];
    assign unused_wr_bits = ^writedata;
    assign wr_en          = chipselect && !write_n;
    assign armed          = (arm_cnt_q == ARM_DONE);

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        mask_d     = mask_q;
        arm_cnt_d  = armed ? arm_cnt_q : arm_cnt_q + 2'd1;

        if (wr_en) begin
            case (address)
                REG_DATA:   data_out_d = wdata;
                REG_DIR:    dir_d      = wdata;
                REG_MASK:   mask_d     = wdata;
                REG_OUTSET: data_out_d = data_out_q | wdata;
                REG_OUTCLR: data_out_d = data_out_q & ~wdata;
                default:    ;
            endcase
        end

        // Clear is applied first so a coincident detected edge re-sets the bit.
        edge_d = edge_q;
        if (wr_en && (address == REG_EDGE)) begin
            edge_d = edge_q & ~wdata;
        end
        if (armed) begin
            edge_d = edge_d | det_w;
        end

        readdata_d = '0;
        case (address)
            REG_DATA: readdata_d[DATA_WIDTH-1:0] = sync_w;
            REG_DIR:  readdata_d[DATA_WIDTH-1:0] = dir_q;
            REG_MASK: readdata_d[DATA_WIDTH-1:0] = mask_q;
            REG_EDGE: readdata_d[DATA_WIDTH-1:0] = edge_q;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= RESET_VALUE;
            dir_q      <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            readdata_q <= '0;
            arm_cnt_q  <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            readdata_q <= readdata_d;
            arm_cnt_q  <= arm_cnt_d;
        end
    end

    assign out_port = data_out_q;
    assign oe       = dir_q;
    assign readdata = readdata_q;
    assign irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_nios_pio_ext.sv
// Directed bench for nios_pio_ext: an 11-bit rising-edge instance and a 4-bit any-edge instance on one bus.
module tb_nios_pio_ext;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] readdata4;
    logic [10:0] in_port;
    logic [10:0] out_port;
    logic [10:0] oe;
    logic        irq;
    logic [3:0]  in_port4;
    logic [3:0]  out_port4;
    logic [3:0]  oe4;
    logic        irq4;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] rd;
    logic [31:0] rd4;

    always #5 clk = ~clk;

    nios_pio_ext #(
        .DATA_WIDTH (11),
        .RESET_VALUE(11'h155),
        .EDGE_TYPE  (0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .out_port  (out_port),
        .oe        (oe),
        .irq       (irq)
    );

    nios_pio_ext #(
        .DATA_WIDTH(4),
        .EDGE_TYPE (2)
    ) dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata4),
        .in_port   (in_port4),
        .out_port  (out_port4),
        .oe        (oe4),
        .irq       (irq4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic [31:0] d4);
        @(negedge clk);
        address = a;
        @(negedge clk);
        d  = readdata;
        d4 = readdata4;
    endtask

    initial begin
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        in_port4   = '0;

        #1 reset_n = 1'b0;
        #1;
        check("rst_out_port",  32'(out_port),  32'h155);
        check("rst_oe",        32'(oe),        32'h0);
        check("rst_irq",       32'(irq),       32'h0);
        check("rst_readdata",  readdata,       32'h0);
        check("rst_out_port4", 32'(out_port4), 32'h0);
        tick(2);
        @(negedge clk) reset_n = 1'b1;
        tick(4);

        // data register write, upper writedata bits ignored
        bus_write(3'd0, 32'h1234_57FF);
        check("wr_out_port",  32'(out_port),  32'h7FF);
        check("wr_out_port4", 32'(out_port4), 32'hF);

        in_port = 11'h2A5;
        tick(3);
        bus_read(3'd0, rd, rd4);
        check("rd_in_port", rd, 32'h2A5);
        @(negedge clk) address = 3'd1;
        #1 check("rd_latency_hold", readdata, 32'h2A5);
        @(negedge clk);
        check("rd_dir_zero", readdata, 32'h0);

        bus_write(3'd1, 32'h0000_003C);
        check("oe",  32'(oe),  32'h03C);
        check("oe4", 32'(oe4), 32'hC);

        // set / clear aliases
        bus_write(3'd0, 32'h0000_00F0);
        check("data_0f0", 32'(out_port), 32'h0F0);
        bus_write(3'd4, 32'h0000_000F);
        check("outset", 32'(out_port), 32'h0FF);
        bus_write(3'd5, 32'h0000_0030);
        check("outclr", 32'(out_port), 32'h0CF);
        bus_read(3'd4, rd, rd4);
        check("rd_outset", rd, 32'h0);
        bus_read(3'd5, rd, rd4);
        check("rd_outclr", rd, 32'h0);
        bus_write(3'd6, 32'h0000_07FF);
        bus_write(3'd7, 32'h0000_07FF);
        check("wr67_out_port", 32'(out_port), 32'h0CF);
        check("wr67_oe",       32'(oe),       32'h03C);
        bus_read(3'd6, rd, rd4);
        check("rd_off6", rd, 32'h0);
        bus_read(3'd7, rd, rd4);
        check("rd_off7", rd, 32'h0);
        bus_read(3'd1, rd, rd4);
        check("rd_dir", rd, 32'h03C);

        // mask readback truncated to width; earlier 0->2A5 rising edges already captured
        bus_write(3'd2, 32'hFFFF_FFFF);
        bus_read(3'd2, rd, rd4);
        check("rd_mask",  rd,  32'h0000_07FF);
        check("rd_mask4", rd4, 32'h0000_000F);
        check("irq_mask_all", 32'(irq), 32'h1);
        bus_read(3'd3, rd, rd4);
        check("rd_edge_2a5", rd, 32'h2A5);
        bus_write(3'd3, 32'h0000_07FF);
        check("irq_w1c_all", 32'(irq), 32'h0);
        bus_read(3'd3, rd, rd4);
        check("rd_edge_clr", rd, 32'h0);

        // rising edge latency on bit 0
        bus_write(3'd2, 32'h0000_0001);
        in_port = '0;
        tick(4);
        bus_read(3'd3, rd, rd4);
        check("fall_not_captured", rd, 32'h0);
        @(negedge clk) in_port = 11'h001;
        @(negedge clk) check("irq_edge_k",  32'(irq), 32'h0);
        @(negedge clk) check("irq_edge_k1", 32'(irq), 32'h0);
        @(negedge clk) check("irq_edge_k2", 32'(irq), 32'h1);
        bus_write(3'd3, 32'h0000_0001);
        check("irq_after_w1c", 32'(irq), 32'h0);

        // masked capture, unmask raises irq, re-mask keeps capture
        @(negedge clk) in_port = 11'h003;
        tick(4);
        check("irq_masked", 32'(irq), 32'h0);
        bus_read(3'd3, rd, rd4);
        check("rd_edge_bit1", rd, 32'h002);
        bus_write(3'd2, 32'h0000_0003);
        check("irq_unmask", 32'(irq), 32'h1);
        bus_write(3'd2, 32'h0000_0000);
        check("irq_remask", 32'(irq), 32'h0);
        bus_read(3'd3, rd, rd4);
        check("rd_edge_kept", rd, 32'h002);
        bus_write(3'd3, 32'h0000_0002);
        bus_read(3'd3, rd, rd4);
        check("rd_edge_clr2", rd, 32'h0);

        // W1C lands on the same clock as a new edge on bit 0
        bus_write(3'd2, 32'h0000_0001);
        @(negedge clk) in_port = '0;
        tick(4);
        bus_read(3'd3, rd, rd4);
        check("rd_edge_pre_race", rd, 32'h0);
        @(negedge clk) in_port = 11'h001;
        @(negedge clk);
        bus_write(3'd3, 32'h0000_0001);
        check("irq_set_wins", 32'(irq), 32'h1);
        bus_read(3'd3, rd, rd4);
        check("rd_set_wins", rd, 32'h001);

        // any-edge instance captures both directions
        @(negedge clk) in_port4 = 4'h4;
        tick(4);
        bus_read(3'd3, rd, rd4);
        check("any_rise", rd4, 32'h4);
        check("irq4_masked", 32'(irq4), 32'h0);
        bus_write(3'd3, 32'h0000_0004);
        bus_read(3'd3, rd, rd4);
        check("any_clr", rd4, 32'h0);
        check("main_edge_kept", rd, 32'h001);
        @(negedge clk) in_port4 = 4'h0;
        tick(4);
        bus_read(3'd3, rd, rd4);
        check("any_fall", rd4, 32'h4);
        bus_write(3'd3, 32'h0000_0004);

        // reset mid-operation with a pending interrupt, inputs high through release
        check("irq_pre_reset", 32'(irq), 32'h1);
        @(negedge clk);
        in_port  = 11'h7FF;
        in_port4 = 4'hF;
        reset_n  = 1'b0;
        #1;
        check("midrst_irq",      32'(irq),      32'h0);
        check("midrst_out_port", 32'(out_port), 32'h155);
        check("midrst_oe",       32'(oe),       32'h0);
        check("midrst_readdata", readdata,      32'h0);
        tick(2);
        @(negedge clk) reset_n = 1'b1;
        bus_write(3'd2, 32'h0000_07FF);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("arm_no_irq", {30'h0, irq4, irq}, 32'h0);
        end
        bus_read(3'd3, rd, rd4);
        check("arm_no_edge",  rd,  32'h0);
        check("arm_no_edge4", rd4, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
